keypad_entry: RTL and testbench

- Front-end writer for the 24-bit `keyboard` bus that the price/litre calculation reads.
- Scans a 4x4 matrix keypad, synchronises and debounces the columns, decodes keys, and assembles up to 6 BCD digits.
- Commits the assembled value to `keyboard` on Enter, with a one-cycle strobe.
- Also exposes the live entry for display, and ignores key actions while the pump is dispensing.

---
 rtl/keypad_entry_pkg.sv | 67 ++++++
 rtl/keypad_entry_scanner.sv | 118 +++++++++++
 rtl/keypad_entry.sv | 96 +++++++++
 tb/tb_keypad_entry.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_entry_pkg.sv
// Shared types, key codes and keypad decode helpers for the keypad entry front-end.
package keypad_entry_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } scan_state_e;

    localparam logic [3:0] K_0   = 4'h0;
    localparam logic [3:0] K_1   = 4'h1;
    localparam logic [3:0] K_2   = 4'h2;
    localparam logic [3:0] K_3   = 4'h3;
    localparam logic [3:0] K_4   = 4'h4;
    localparam logic [3:0] K_5   = 4'h5;
    localparam logic [3:0] K_6   = 4'h6;
    localparam logic [3:0] K_7   = 4'h7;
    localparam logic [3:0] K_8   = 4'h8;
    localparam logic [3:0] K_9   = 4'h9;
    localparam logic [3:0] K_BS  = 4'hA;
    localparam logic [3:0] K_ENT = 4'hB;
    localparam logic [3:0] K_CLR = 4'hC;
    localparam logic [3:0] K_NOP = 4'hF;

    localparam int unsigned BCD_DIGITS = 6;

    // True when exactly one column is pulled low; chords count as no key.
    function automatic logic single_low(input logic [3:0] col);
        int unsigned zeros;
        zeros = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!col[i]) zeros++;
        end
        return (zeros == 1);
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!col[3 - i]) idx = 2'(3 - i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = K_1;
            4'h1: code = K_2;
            4'h2: code = K_3;
            4'h3: code = K_CLR;
            4'h4: code = K_4;
            4'h5: code = K_5;
            4'h6: code = K_6;
            4'h8: code = K_7;
            4'h9: code = K_8;
            4'hA: code = K_9;
            4'hC: code = K_BS;
            4'hD: code = K_0;
            4'hE: code = K_ENT;
            default: code = K_NOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_scanner.sv
// Row scanner, column synchroniser and press/release debouncer; emits one strobe per press.
module keypad_scanner
    import keypad_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 5000,
    parameter int unsigned DEBOUNCE_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_strobe
);

    localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    scan_state_e   state_q, state_d;
    logic [3:0]    col_meta_q, col_s_q;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    cap_col_q, cap_col_d;
    logic [3:0]    key_q, key_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_meta_q <= 4'hF;
            col_s_q    <= 4'hF;
            state_q    <= SCAN;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            row_idx_q  <= 2'd0;
            cap_col_q  <= 4'hF;
            key_q      <= K_NOP;
        end else begin
            col_meta_q <= col_n;
            col_s_q    <= col_meta_q;
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            deb_cnt_q  <= deb_cnt_d;
            row_idx_q  <= row_idx_d;
            cap_col_q  <= cap_col_d;
            key_q      <= key_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        row_idx_d  = row_idx_q;
        cap_col_d  = cap_col_q;
        key_d      = key_q;
        key_strobe = 1'b0;

        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (single_low(col_s_q)) begin
                        cap_col_d = col_s_q;
                        key_d     = key_decode(row_idx_q, col_index(col_s_q));
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (col_s_q == cap_col_q) begin
                    // The cycle that would bring the count to DEBOUNCE_CYC is the execute cycle.
                    if (deb_cnt_q == DEB_LAST) begin
                        key_strobe = 1'b1;
                        deb_cnt_d  = '0;
                        state_d    = HOLD;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end
            end
            HOLD: begin
                if (col_s_q == 4'hF) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        deb_cnt_d  = '0;
                        scan_cnt_d = '0;
                        state_d    = SCAN;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end
            default: begin
                state_d    = SCAN;
                deb_cnt_d  = '0;
                scan_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        row_n    = ~(4'b0001 << row_idx_q);
        key_code = key_q;
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry top: BCD entry buffer, backspace/clear/enter actions and committed amount.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 5000,
    parameter int unsigned DEBOUNCE_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  col_n,
    input  logic        lock,
    output logic [3:0]  row_n,
    output logic [23:0] keyboard,
    output logic [23:0] entry,
    output logic [2:0]  digit_cnt,
    output logic        done
);

    logic [3:0]  key_code;
    logic        key_strobe;
    logic [23:0] keyboard_q, keyboard_d;
    logic [23:0] entry_q, entry_d;
    logic [2:0]  digit_cnt_q, digit_cnt_d;
    logic        done_q, done_d;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_scanner (
        .clk        (clk),
        .reset      (reset),
        .col_n      (col_n),
        .row_n      (row_n),
        .key_code   (key_code),
        .key_strobe (key_strobe)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keyboard_q  <= '0;
            entry_q     <= '0;
            digit_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            keyboard_q  <= keyboard_d;
            entry_q     <= entry_d;
            digit_cnt_q <= digit_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        keyboard_d  = keyboard_q;
        entry_d     = entry_q;
        digit_cnt_d = digit_cnt_q;
        done_d      = 1'b0;

        // A locked pump swallows the press; the scanner still moves on to HOLD.
        if (key_strobe && !lock) begin
            case (key_code)
                K_BS: begin
                    if (digit_cnt_q != 3'd0) begin
                        entry_d     = {4'h0, entry_q[23:4]};
                        digit_cnt_d = digit_cnt_q - 3'd1;
                    end
                end
                K_ENT: begin
                    if (digit_cnt_q != 3'd0) begin
                        keyboard_d  = entry_q;
                        done_d      = 1'b1;
                        entry_d     = '0;
                        digit_cnt_d = '0;
                    end
                end
                K_CLR: begin
                    entry_d     = '0;
                    digit_cnt_d = '0;
                end
                default: begin
                    if (key_code <= K_9 && digit_cnt_q < 3'(BCD_DIGITS)) begin
                        entry_d     = {entry_q[19:0], key_code};
                        digit_cnt_d = digit_cnt_q + 3'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        keyboard  = keyboard_q;
        entry     = entry_q;
        digit_cnt = digit_cnt_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad model drives col_n from row_n and a key mask.
module tb_keypad_entry;

    typedef struct packed {
        logic [23:0] entry;
        logic [2:0]  cnt;
        logic [23:0] kb;
        logic        done;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  col_n;
    logic        lock;
    logic [3:0]  row_n;
    logic [23:0] keyboard;
    logic [23:0] entry;
    logic [2:0]  digit_cnt;
    logic        done;

    logic [15:0] key_mask;
    logic        mon_en;
    exp_t        exp_q[$];
    exp_t        prev_snap;
    int          compared;
    int          mismatched;

    keypad_entry #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col_n     (col_n),
        .lock      (lock),
        .row_n     (row_n),
        .keyboard  (keyboard),
        .entry     (entry),
        .digit_cnt (digit_cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to its column.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4 + c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    // Monitor: every visible change of the output state pops one expectation.
    always @(negedge clk) begin
        exp_t snap;
        exp_t e;
        snap = '{entry: entry, cnt: digit_cnt, kb: keyboard, done: done};
        if (mon_en && snap != prev_snap) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_update: got entry=%h cnt=%0d kb=%h done=%b, required no change",
                         entry, digit_cnt, keyboard, done);
            end else begin
                e = exp_q.pop_front();
                if (snap != e) begin
                    mismatched++;
                    $display("FAIL update: got entry=%h cnt=%0d kb=%h done=%b, required entry=%h cnt=%0d kb=%h done=%b",
                             entry, digit_cnt, keyboard, done, e.entry, e.cnt, e.kb, e.done);
                end
            end
        end
        prev_snap = snap;
    end

    task automatic expect_upd(input logic [23:0] en, input logic [2:0] cnt,
                              input logic [23:0] kb, input logic dn);
        exp_t e;
        e = '{entry: en, cnt: cnt, kb: kb, done: dn};
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int idx, input int hold_cyc, input int rel_cyc);
        key_mask[idx] = 1'b1;
        cycles(hold_cyc);
        key_mask[idx] = 1'b0;
        cycles(rel_cyc);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            cycles(1);
            budget--;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_%s: %0d expected updates never seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic check24(input string name, input logic [23:0] got, input logic [23:0] req);
        compared++;
        if (got !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    initial begin
        logic [3:0] exp_row;
        compared   = 0;
        mismatched = 0;
        mon_en     = 1'b0;
        key_mask   = '0;
        lock       = 1'b0;
        reset      = 1'b0;
        cycles(3);

        check4("reset_row_n", row_n, 4'b1110);
        check24("reset_keyboard", keyboard, 24'h0);
        check24("reset_entry", entry, 24'h0);
        check4("reset_cnt_done", {digit_cnt, done}, 4'b0000);

        reset  = 1'b1;
        mon_en = 1'b1;
        // 1: idle scan, row advances every 4 cycles
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk);
            #1;
            exp_row = ~(4'b0001 << ((n / 4) % 4));
            check4("scan_row_n", row_n, exp_row);
        end

        // 2: 1, 2, 5, enter
        expect_upd(24'h000001, 3'd1, 24'h0, 1'b0);
        press(0, 40, 40);
        expect_upd(24'h000012, 3'd2, 24'h0, 1'b0);
        press(1, 40, 40);
        expect_upd(24'h000125, 3'd3, 24'h0, 1'b0);
        press(5, 40, 40);
        expect_upd(24'h000000, 3'd0, 24'h000125, 1'b1);
        expect_upd(24'h000000, 3'd0, 24'h000125, 1'b0);
        press(14, 40, 40);
        drain("enter");

        // 3: eight 9s saturate at six digits, then backspace and clear
        expect_upd(24'h000009, 3'd1, 24'h000125, 1'b0);
        expect_upd(24'h000099, 3'd2, 24'h000125, 1'b0);
        expect_upd(24'h000999, 3'd3, 24'h000125, 1'b0);
        expect_upd(24'h009999, 3'd4, 24'h000125, 1'b0);
        expect_upd(24'h099999, 3'd5, 24'h000125, 1'b0);
        expect_upd(24'h999999, 3'd6, 24'h000125, 1'b0);
        for (int k = 0; k < 8; k++) press(10, 40, 40);
        drain("saturate");
        expect_upd(24'h099999, 3'd5, 24'h000125, 1'b0);
        press(12, 40, 40);
        expect_upd(24'h000000, 3'd0, 24'h000125, 1'b0);
        press(3, 40, 40);
        drain("bs_clear");

        // 4: bouncing 7 gives one action; a 5-cycle tap of 8 gives none
        expect_upd(24'h000007, 3'd1, 24'h000125, 1'b0);
        key_mask[8] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycles(3);
            key_mask[8] = ~key_mask[8];
        end
        key_mask[8] = 1'b1;
        cycles(40);
        key_mask[8] = 1'b0;
        cycles(40);
        press(9, 5, 40);
        drain("bounce");

        // 5: locked presses are discarded
        expect_upd(24'h000000, 3'd0, 24'h000125, 1'b0);
        press(3, 40, 40);
        drain("pre_lock_clear");
        lock = 1'b1;
        press(2, 40, 40);
        press(14, 40, 40);
        lock = 1'b0;
        cycles(5);
        check24("lock_keyboard", keyboard, 24'h000125);
        expect_upd(24'h000003, 3'd1, 24'h000125, 1'b0);
        press(2, 40, 40);
        drain("unlock");

        // 6: same-row chord is no key; reset in HOLD abandons the key
        key_mask[0] = 1'b1;
        key_mask[1] = 1'b1;
        cycles(40);
        key_mask = '0;
        cycles(40);
        drain("chord");
        expect_upd(24'h000034, 3'd2, 24'h000125, 1'b0);
        key_mask[4] = 1'b1;
        drain("pre_reset_digit");
        cycles(2);
        expect_upd(24'h000000, 3'd0, 24'h000000, 1'b0);
        reset = 1'b0;
        #1;
        check4("midhold_reset_row_n", row_n, 4'b1110);
        check24("midhold_reset_entry", entry, 24'h0);
        key_mask[4] = 1'b0;
        cycles(5);
        reset = 1'b1;
        cycles(60);
        drain("after_reset");
        expect_upd(24'h000004, 3'd1, 24'h000000, 1'b0);
        press(4, 40, 40);
        drain("repress");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
